ascii_scan_encoder: RTL and testbench

ASCII_SCAN_ENCODER -- requirements
Module: ascii_scan_encoder

---
 rtl/ascii_scan_pkg.sv | 54 +++++
 rtl/ascii_scan_encoder_lut.sv | 52 +++++
 rtl/ascii_scan_encoder.sv | 164 ++++++++++++++++
 tb/tb_ascii_scan_encoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_scan_pkg.sv
// Shared constants and types for the ASCII to PS/2 set-2 scan encoder.
// KEY_BREAK_EN: when defined, break codes (F0 sequences) are emitted after make codes.
package ascii_scan_pkg;

   // Scan prefix bytes
   localparam logic [7:0] SCAN_EXT   = 8'hE0;
   localparam logic [7:0] SCAN_BRK   = 8'hF0;

   // Control and arrow key scan codes (arrows are extended keys)
   localparam logic [7:0] SCAN_SPACE = 8'h29;
   localparam logic [7:0] SCAN_ENTER = 8'h5A;
   localparam logic [7:0] SCAN_BKSP  = 8'h66;
   localparam logic [7:0] SCAN_ESC   = 8'h76;
   localparam logic [7:0] SCAN_RIGHT = 8'h74;
   localparam logic [7:0] SCAN_LEFT  = 8'h6B;
   localparam logic [7:0] SCAN_UP    = 8'h75;
   localparam logic [7:0] SCAN_DOWN  = 8'h72;

   // Digit codes, indexed by digit value 0..9
   localparam logic [7:0] SCAN_DIGIT [10] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
   };

   // Letter codes, indexed by letter position A=0 .. Z=25
   localparam logic [7:0] SCAN_LETTER [26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
      8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
      8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
   };

   // ASCII control characters with a key mapping
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_ESC   = 8'h1B;
   localparam logic [7:0] ASCII_RIGHT = 8'h1C;
   localparam logic [7:0] ASCII_LEFT  = 8'h1D;
   localparam logic [7:0] ASCII_UP    = 8'h1E;
   localparam logic [7:0] ASCII_DOWN  = 8'h1F;

   // Encoder FSM states; break states exist only when break codes are enabled
   typedef enum logic [2:0] {
      IDLE,
      EXT_MK,
      MAKE,
`ifdef KEY_BREAK_EN
      EXT_BK,
      BRK,
      CODE_BK,
`endif
      GAP
   } state_t;

endpackage

// File: rtl/ascii_scan_encoder_lut.sv
// Combinational ASCII to set-2 scan code lookup.
// Letters are case-insensitive; arrows (0x1C..0x1F) are flagged as extended keys.
module ascii_scan_lut
   import ascii_scan_pkg::*;
(
   input  logic [7:0] ascii,
   output logic [7:0] code,
   output logic       extended,
   output logic       valid
);

   logic       is_digit;
   logic       is_letter;
   logic [3:0] digit_idx;
   logic [4:0] letter_idx;

   // Classify the character; the low bits directly give the table index
   always_comb begin
      is_digit   = (ascii >= 8'h30) && (ascii <= 8'h39);
      is_letter  = ((ascii >= 8'h41) && (ascii <= 8'h5A)) ||
                   ((ascii >= 8'h61) && (ascii <= 8'h7A));
      digit_idx  = ascii[3:0];
      letter_idx = ascii[4:0] - 5'd1;
   end

   // Select the scan code and its extended flag
   always_comb begin
      code     = 8'h00;
      extended = 1'b0;
      valid    = 1'b0;
      if (is_digit) begin
         code  = SCAN_DIGIT[digit_idx];
         valid = 1'b1;
      end else if (is_letter) begin
         code  = SCAN_LETTER[letter_idx];
         valid = 1'b1;
      end else begin
         case (ascii)
            ASCII_SPACE: begin code = SCAN_SPACE; valid = 1'b1; end
            ASCII_CR:    begin code = SCAN_ENTER; valid = 1'b1; end
            ASCII_BS:    begin code = SCAN_BKSP;  valid = 1'b1; end
            ASCII_ESC:   begin code = SCAN_ESC;   valid = 1'b1; end
            ASCII_RIGHT: begin code = SCAN_RIGHT; valid = 1'b1; extended = 1'b1; end
            ASCII_LEFT:  begin code = SCAN_LEFT;  valid = 1'b1; extended = 1'b1; end
            ASCII_UP:    begin code = SCAN_UP;    valid = 1'b1; extended = 1'b1; end
            ASCII_DOWN:  begin code = SCAN_DOWN;  valid = 1'b1; extended = 1'b1; end
            default:     begin code = 8'h00;      valid = 1'b0; end
         endcase
      end
   end

endmodule

// File: rtl/ascii_scan_encoder.sv
// ASCII character to PS/2 set-2 scan byte sequence encoder.
// Each accepted character becomes a make sequence (and, with KEY_BREAK_EN defined,
// a following break sequence) streamed out over a valid/ready byte interface,
// with BYTE_GAP idle cycles between consecutive bytes of one character.
module ascii_scan_encoder
   import ascii_scan_pkg::*;
#(
   parameter int BYTE_GAP = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ascii_in,
   input  logic       ascii_valid,
   output logic       ascii_ready,
   output logic [7:0] scan_out,
   output logic       scan_valid,
   input  logic       scan_ready,
   output logic       unmapped
);

   // Value loaded into the gap counter when entering GAP (counts down to 0)
   localparam logic [7:0] GAP_LOAD = (BYTE_GAP > 0) ? 8'(BYTE_GAP - 1) : 8'd0;

   state_t     state_reg, state_next;
   state_t     resume_reg, resume_next;
   state_t     follow;
   logic [7:0] code_reg, code_next;
   logic [7:0] gap_cnt_reg, gap_cnt_next;
   logic       unmapped_reg, unmapped_next;
   logic       last_byte;
   logic       accept;

`ifdef KEY_BREAK_EN
   // The extended flag only steers the choice of break prefix
   logic       ext_reg, ext_next;
`endif

   logic [7:0] lut_code;
   logic       lut_ext;
   logic       lut_valid;

   ascii_scan_lut u_lut (
      .ascii    (ascii_in),
      .code     (lut_code),
      .extended (lut_ext),
      .valid    (lut_valid)
   );

   assign accept   = ascii_valid && ascii_ready;
   assign unmapped = unmapped_reg;

   // Next-state, byte selection and handshake outputs
   always_comb begin
      state_next    = state_reg;
      resume_next   = resume_reg;
      code_next     = code_reg;
      gap_cnt_next  = gap_cnt_reg;
      unmapped_next = 1'b0;
`ifdef KEY_BREAK_EN
      ext_next      = ext_reg;
`endif
      ascii_ready   = 1'b0;
      scan_valid    = 1'b0;
      scan_out      = 8'h00;
      follow        = IDLE;
      last_byte     = 1'b0;

      case (state_reg)
         IDLE: begin
            // Hold off one cycle after an unmapped character so its pulse is isolated
            ascii_ready = !unmapped_reg;
            if (accept) begin
               if (lut_valid) begin
                  code_next  = lut_code;
`ifdef KEY_BREAK_EN
                  ext_next   = lut_ext;
`endif
                  state_next = lut_ext ? EXT_MK : MAKE;
               end else begin
                  unmapped_next = 1'b1;
               end
            end
         end
         EXT_MK: begin
            scan_valid = 1'b1;
            scan_out   = SCAN_EXT;
            follow     = MAKE;
         end
         MAKE: begin
            scan_valid = 1'b1;
            scan_out   = code_reg;
`ifdef KEY_BREAK_EN
            follow     = ext_reg ? EXT_BK : BRK;
`else
            last_byte  = 1'b1;
`endif
         end
`ifdef KEY_BREAK_EN
         EXT_BK: begin
            scan_valid = 1'b1;
            scan_out   = SCAN_EXT;
            follow     = BRK;
         end
         BRK: begin
            scan_valid = 1'b1;
            scan_out   = SCAN_BRK;
            follow     = CODE_BK;
         end
         CODE_BK: begin
            scan_valid = 1'b1;
            scan_out   = code_reg;
            last_byte  = 1'b1;
         end
`endif
         GAP: begin
            if (gap_cnt_reg == 8'd0) begin
               state_next = resume_reg;
            end else begin
               gap_cnt_next = gap_cnt_reg - 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Byte handed off: finish, move straight on, or idle for the gap first
      if (scan_valid && scan_ready) begin
         if (last_byte) begin
            state_next = IDLE;
         end else if (BYTE_GAP == 0) begin
            state_next = follow;
         end else begin
            state_next   = GAP;
            resume_next  = follow;
            gap_cnt_next = GAP_LOAD;
         end
      end
   end

   // State and captured lookup registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         resume_reg   <= IDLE;
         code_reg     <= 8'h00;
         gap_cnt_reg  <= 8'd0;
         unmapped_reg <= 1'b0;
`ifdef KEY_BREAK_EN
         ext_reg      <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         resume_reg   <= resume_next;
         code_reg     <= code_next;
         gap_cnt_reg  <= gap_cnt_next;
         unmapped_reg <= unmapped_next;
`ifdef KEY_BREAK_EN
         ext_reg      <= ext_next;
`endif
      end
   end

endmodule

// File: tb/tb_ascii_scan_encoder.sv
// Directed testbench for ascii_scan_encoder: one DUT with BYTE_GAP=0 and one with
// BYTE_GAP=3, selected for stimulus/monitoring through sel.
module tb_ascii_scan_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ascii_in = 8'h00;
   logic       ascii_valid = 1'b0;
   logic       scan_ready = 1'b1;
   logic       sel = 1'b0;

   logic       ready_d, valid_d, unm_d;
   logic [7:0] out_d;
   logic       ready_g, valid_g, unm_g;
   logic [7:0] out_g;

   logic       ready_m, valid_m, unm_m;
   logic [7:0] out_m;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ascii_scan_encoder #(.BYTE_GAP(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .ascii_in(ascii_in), .ascii_valid(ascii_valid & ~sel),
      .ascii_ready(ready_d), .scan_out(out_d), .scan_valid(valid_d),
      .scan_ready(scan_ready), .unmapped(unm_d)
   );

   ascii_scan_encoder #(.BYTE_GAP(3)) u_dut_gap (
      .clk(clk), .rst_n(rst_n), .ascii_in(ascii_in), .ascii_valid(ascii_valid & sel),
      .ascii_ready(ready_g), .scan_out(out_g), .scan_valid(valid_g),
      .scan_ready(scan_ready), .unmapped(unm_g)
   );

   assign ready_m = sel ? ready_g : ready_d;
   assign valid_m = sel ? valid_g : valid_d;
   assign unm_m   = sel ? unm_g   : unm_d;
   assign out_m   = sel ? out_g   : out_d;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = %0h", tag, got);
      end
   endtask

   // Expected byte stream, first byte in the top byte
   function automatic logic [39:0] seq(input logic [7:0] c, input bit ext);
`ifdef KEY_BREAK_EN
      seq = ext ? {8'hE0, c, 8'hE0, 8'hF0, c} : {c, 8'hF0, c, 16'h0000};
`else
      seq = ext ? {8'hE0, c, 24'h000000} : {c, 32'h00000000};
`endif
   endfunction

   function automatic int seq_len(input bit ext);
`ifdef KEY_BREAK_EN
      seq_len = ext ? 5 : 3;
`else
      seq_len = ext ? 2 : 1;
`endif
   endfunction

   // Wait for ascii_ready, present one character; returns #1 after the accept edge
   task automatic send(input logic [7:0] c);
      int w = 0;
      @(negedge clk);
      while (!ready_m && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!ready_m) check("send_ready_timeout", 32'(ready_m), 32'd1);
      ascii_in    = c;
      ascii_valid = 1'b1;
      @(posedge clk);
      #1 ascii_valid = 1'b0;
   endtask

   // Collect bytes after an accept with scan_ready=1, checking value and cycle of each;
   // junk>0 holds ascii_valid high with '9' for that many busy cycles
   task automatic collect(input logic [39:0] exp, input int n, input int gap,
                          input int junk, input string name);
      int got = 0;
      int k = 0;
      int extra = 0;
      logic [7:0] eb;
      if (junk > 0) begin
         ascii_in    = 8'h39;
         ascii_valid = 1'b1;
      end
      while (got < n && k < 200) begin
         k++;
         @(negedge clk);
         if (k >= junk) ascii_valid = 1'b0;
         if (valid_m && scan_ready) begin
            eb = exp[39 - 8*got -: 8];
            check($sformatf("%s byte%0d", name, got), 32'(out_m), 32'(eb));
            check($sformatf("%s byte%0d cycle", name, got), k, 1 + got*(gap + 1));
            got++;
         end
      end
      if (got < n) check($sformatf("%s byte_timeout", name), got, n);
      @(negedge clk);
      check($sformatf("%s ready_after", name), 32'(ready_m), 32'd1);
      repeat (6) begin
         @(negedge clk);
         if (valid_m) extra++;
      end
      check($sformatf("%s no_extra", name), extra, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] held;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst scan_valid", 32'(valid_d), 32'd0);
      check("rst scan_out", 32'(out_d), 32'h00);
      check("rst unmapped", 32'(unm_d), 32'd0);
      check("rst gap scan_valid", 32'(valid_g), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst ascii_ready", 32'(ready_d), 32'd1);

      // Normal and extended keys, back-to-back consumer
      send(8'h41); collect(seq(8'h1C, 1'b0), seq_len(1'b0), 0, 0, "A");
      send(8'h1E); collect(seq(8'h75, 1'b1), seq_len(1'b1), 0, 0, "up");
      send(8'h7A); collect(seq(8'h1A, 1'b0), seq_len(1'b0), 0, 0, "z");
      send(8'h0D); collect(seq(8'h5A, 1'b0), seq_len(1'b0), 0, 0, "cr");
      send(8'h39); collect(seq(8'h46, 1'b0), seq_len(1'b0), 0, 0, "9");
      send(8'h20); collect(seq(8'h29, 1'b0), seq_len(1'b0), 0, 0, "space");
      send(8'h08); collect(seq(8'h66, 1'b0), seq_len(1'b0), 0, 0, "bs");
      send(8'h1B); collect(seq(8'h76, 1'b0), seq_len(1'b0), 0, 0, "esc");

      // Character offered while busy must be ignored
      send(8'h1C); collect(seq(8'h74, 1'b1), seq_len(1'b1), 0, 2, "right_busy");

      // Unmapped character, then next character two cycles after the first accept
      send(8'h3F);
      @(negedge clk);
      check("unm pulse", 32'(unm_m), 32'd1);
      check("unm ready_low", 32'(ready_m), 32'd0);
      check("unm scan_valid", 32'(valid_m), 32'd0);
      @(negedge clk);
      check("unm pulse_end", 32'(unm_m), 32'd0);
      check("unm ready_back", 32'(ready_m), 32'd1);
      check("unm scan_valid2", 32'(valid_m), 32'd0);
      ascii_in    = 8'h31;
      ascii_valid = 1'b1;
      @(posedge clk);
      #1 ascii_valid = 1'b0;
      collect(seq(8'h16, 1'b0), seq_len(1'b0), 0, 0, "one");

      // Back-pressure: hold scan_ready low for 4 cycles on a byte
      send(8'h35);
`ifdef KEY_BREAK_EN
      held = 8'hF0;
      @(negedge clk);
      check("stall first", 32'(out_m), 32'h2E);
      check("stall first_valid", 32'(valid_m), 32'd1);
      @(posedge clk);
      #1 scan_ready = 1'b0;
`else
      held = 8'h2E;
      scan_ready = 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("stall hold%0d", i), 32'(out_m), 32'(held));
         check($sformatf("stall valid%0d", i), 32'(valid_m), 32'd1);
      end
      @(posedge clk);
      #1 scan_ready = 1'b1;
      @(negedge clk);
      check("stall release", 32'(out_m), 32'(held));
`ifdef KEY_BREAK_EN
      @(negedge clk);
      check("stall next", 32'(out_m), 32'h2E);
      check("stall next_valid", 32'(valid_m), 32'd1);
`endif
      @(negedge clk);
      check("stall ready_after", 32'(ready_m), 32'd1);

      // Reset in the middle of an extended sequence
      send(8'h1D);
      @(negedge clk);
      check("rstmid first", 32'(out_m), 32'hE0);
      check("rstmid first_valid", 32'(valid_m), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rstmid scan_valid", 32'(valid_m), 32'd0);
      check("rstmid scan_out", 32'(out_m), 32'h00);
      check("rstmid ready", 32'(ready_m), 32'd1);
      begin
         int extra = 0;
         repeat (8) begin
            @(negedge clk);
            if (valid_m) extra++;
         end
         check("rstmid no_bytes", extra, 0);
      end

      // BYTE_GAP=3 instance
      sel = 1'b1;
      send(8'h61); collect(seq(8'h1C, 1'b0), seq_len(1'b0), 3, 0, "gap a");
      send(8'h1F); collect(seq(8'h72, 1'b1), seq_len(1'b1), 3, 0, "gap down");
      sel = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
